uart_tx_ctrl: RTL and testbench

Transmit-side controller for the UART. Drains bytes from the TX FIFO, which presents show-ahead read data (rdata is the head entry whenever not empty; ren pops it). Serializes each byte onto txd as an 8N1-style frame: start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits. Sits between the TX FIFO instance and the pad; the CPU side writes the FIFO and observes tx_busy and tx_done.

---
 rtl/uart_tx_ctrl_pkg.sv | 22 ++
 rtl/uart_tx_ctrl_if.sv | 11 +
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_tx_ctrl.sv | 124 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and defaults for the UART transmit path.
// The RX controller reuses the same frame-state encoding.
package uart_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_DATA_BITS   = 8;
  localparam int unsigned DEF_STOP_BITS   = 1;
  localparam int unsigned DEF_CLK_PER_BIT = 868;
  localparam int unsigned DEF_CNT_WIDTH   = 10;

  // Sized for up to 8 data bits and up to 2 stop bits
  localparam int unsigned BIT_IDX_W  = 3;
  localparam int unsigned STOP_IDX_W = 1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Show-ahead TX FIFO read port: master is the FIFO, slave is the transmitter.
interface uart_tx_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_ren;

  modport master (output fifo_empty, output fifo_rdata, input fifo_ren);
  modport slave  (input fifo_empty, input fifo_rdata, output fifo_ren);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter with clear/enable; o_term_c flags the last cycle of a bit.
module uart_baud_cnt #(
  parameter int unsigned CNT_WIDTH   = 10,
  parameter int unsigned CLK_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term_c
);

  localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(CLK_PER_BIT - 1);

  logic [CNT_WIDTH-1:0] r_cnt;

  assign o_term_c = i_en && (r_cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_term_c ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops bytes from a show-ahead FIFO and frames them
// as start + DATA_BITS (LSB first) + STOP_BITS on txd.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
  parameter int unsigned STOP_BITS   = DEF_STOP_BITS,
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_tx_en,
  uart_tx_ctrl_if.slave  fifo,
  output logic           o_txd,
  output logic           o_tx_busy,
  output logic           o_tx_done
);

  tx_state_e               r_state;
  logic                    r_txd;
  logic                    r_busy;
  logic                    r_done;
  logic [DATA_BITS-1:0]    r_shift;
  logic [BIT_IDX_W-1:0]    r_bit_idx;
  logic [STOP_IDX_W-1:0]   r_stop_idx;

  logic                    w_term;
  logic                    w_last_stop;
  logic                    w_pop;
  logic [DATA_BITS-1:0]    w_rdata;

  assign w_rdata = fifo.fifo_rdata[DATA_BITS-1:0];

  generate
    if (WIDTH > DATA_BITS) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^fifo.fifo_rdata[WIDTH-1:DATA_BITS];
    end
  endgenerate

  // A new frame may start from idle or on the final stop cycle (no idle gap)
  assign w_last_stop = (r_state == ST_STOP) && w_term &&
                       (r_stop_idx == STOP_IDX_W'(STOP_BITS - 1));
  assign w_pop = !rst && i_tx_en && !fifo.fifo_empty &&
                 ((r_state == ST_IDLE) || w_last_stop);
  assign fifo.fifo_ren = w_pop;

  uart_baud_cnt #(
    .CNT_WIDTH   (CNT_WIDTH),
    .CLK_PER_BIT (CLK_PER_BIT)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_pop),
    .i_en     (r_state != ST_IDLE),
    .o_term_c (w_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) begin
        r_state <= ST_START;
        r_shift <= w_rdata;
        r_txd   <= 1'b0;
        r_busy  <= 1'b1;
        r_done  <= w_last_stop;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_txd <= 1'b1;
          end
          ST_START: begin
            if (w_term) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
              r_txd     <= r_shift[0];
            end
          end
          ST_DATA: begin
            if (w_term) begin
              r_shift <= r_shift >> 1;
              if (r_bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                r_state    <= ST_STOP;
                r_stop_idx <= '0;
                r_txd      <= 1'b1;
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
                r_txd     <= r_shift[1];
              end
            end
          end
          ST_STOP: begin
            if (w_last_stop) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_term) begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_txd     = r_txd;
  assign o_tx_busy = r_busy;
  assign o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two configurations driven in lock-step against a
// frame-level reference model, plus directed scenarios with literal checks.
module tb_uart_tx_ctrl;

  localparam int TR_N = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] en  = 2'b00;
  logic [1:0] txd, busy, done;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.WIDTH(8)) if0 ();
  uart_tx_ctrl_if #(.WIDTH(8)) if1 ();

  uart_tx_ctrl #(
    .WIDTH(8), .DATA_BITS(8), .STOP_BITS(1), .CLK_PER_BIT(4), .CNT_WIDTH(3)
  ) u_dut0 (
    .clk(clk), .rst(rst), .i_tx_en(en[0]), .fifo(if0.slave),
    .o_txd(txd[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0])
  );

  uart_tx_ctrl #(
    .WIDTH(8), .DATA_BITS(7), .STOP_BITS(2), .CLK_PER_BIT(3), .CNT_WIDTH(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .i_tx_en(en[1]), .fifo(if1.slave),
    .o_txd(txd[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1])
  );

  // Per-channel configuration mirrored from the instance parameters
  int cpb [2] = '{4, 3};
  int db  [2] = '{8, 7};
  int sb  [2] = '{1, 2};

  // Frame-level model: active flag, cycle position within frame, frame bit image
  bit          m_act  [2];
  int          m_t    [2];
  bit          m_done [2];
  logic [15:0] m_bits [2];

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  int   fall_c [2][64];
  int   done_c [2][64];
  int   ren_c  [2][64];
  int   n_fall [2];
  int   n_done [2];
  int   n_ren  [2];
  logic prev_txd [2] = '{1'b1, 1'b1};
  logic tr_txd  [2][TR_N];
  logic tr_busy [2][TR_N];

  function automatic void chk_b(string nm, int ch, logic got, logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s ch%0d cyc=%0d got=%b expected=%b", nm, ch, cyc, got, exp);
    end
  endfunction

  function automatic void chk_i(string nm, int ch, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s ch%0d cyc=%0d got=%0d expected=%0d", nm, ch, cyc, got, exp);
    end
  endfunction

  function automatic int flen(int ch);
    return (1 + db[ch] + sb[ch]) * cpb[ch];
  endfunction

  function automatic int qsize(int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qfront(int ch);
    return (ch == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpush(int ch, logic [7:0] v);
    if (ch == 0) q0.push_back(v);
    else         q1.push_back(v);
  endfunction

  function automatic void qpop(int ch);
    if (ch == 0) void'(q0.pop_front());
    else         void'(q1.pop_front());
  endfunction

  // Line image of one frame: bit 0 start, then data LSB first, then stop ones
  function automatic logic [15:0] mk_frame(int ch, logic [7:0] b);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < db[ch]; i++) f[1+i] = b[i];
    return f;
  endfunction

  // One clock: drive FIFO view, compare every output, then advance the model
  task automatic step();
    logic e_ren [2];
    logic g_ren [2];
    logic e_txd;
    @(negedge clk);
    if0.fifo_empty = (q0.size() == 0);
    if0.fifo_rdata = (q0.size() != 0) ? q0[0] : 8'($urandom);
    if1.fifo_empty = (q1.size() == 0);
    if1.fifo_rdata = (q1.size() != 0) ? q1[0] : 8'($urandom);
    #1;
    g_ren[0] = if0.fifo_ren;
    g_ren[1] = if1.fifo_ren;
    for (int ch = 0; ch < 2; ch++) begin
      e_ren[ch] = !rst && en[ch] && (qsize(ch) > 0) &&
                  (!m_act[ch] || (m_t[ch] == flen(ch) - 1));
      e_txd = m_act[ch] ? m_bits[ch][m_t[ch] / cpb[ch]] : 1'b1;
      chk_b("fifo_ren", ch, g_ren[ch], e_ren[ch]);
      chk_b("txd",      ch, txd[ch],   e_txd);
      chk_b("tx_busy",  ch, busy[ch],  m_act[ch]);
      chk_b("tx_done",  ch, done[ch],  m_done[ch]);
      if (cyc < TR_N) begin
        tr_txd[ch][cyc]  = txd[ch];
        tr_busy[ch][cyc] = busy[ch];
      end
      if (prev_txd[ch] === 1'b1 && txd[ch] === 1'b0 && n_fall[ch] < 64)
        fall_c[ch][n_fall[ch]++] = cyc;
      prev_txd[ch] = txd[ch];
      if (done[ch] === 1'b1 && n_done[ch] < 64) done_c[ch][n_done[ch]++] = cyc;
      if (g_ren[ch] === 1'b1 && n_ren[ch] < 64) ren_c[ch][n_ren[ch]++] = cyc;
    end
    @(posedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        m_act[ch]  = 1'b0;
        m_t[ch]    = 0;
        m_done[ch] = 1'b0;
      end else begin
        m_done[ch] = m_act[ch] && (m_t[ch] == flen(ch) - 1);
        if (e_ren[ch]) begin
          m_bits[ch] = mk_frame(ch, qfront(ch));
          qpop(ch);
          m_act[ch] = 1'b1;
          m_t[ch]   = 0;
        end else if (m_act[ch]) begin
          if (m_t[ch] == flen(ch) - 1) m_act[ch] = 1'b0;
          else                         m_t[ch]++;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic wait_done(int ch, int target, int budget);
    int k;
    k = 0;
    while (n_done[ch] < target && k < budget) begin
      step();
      k++;
    end
    chk_i("wait_done", ch, n_done[ch], target);
  endtask

  task automatic wait_ren(int ch, int target, int budget);
    int k;
    k = 0;
    while (n_ren[ch] < target && k < budget) begin
      step();
      k++;
    end
    chk_i("wait_ren", ch, n_ren[ch], target);
  endtask

  initial begin
    int f, f2, d1, d2, r2, br, bd, bf, cnt, k;
    logic [9:0] pat;
    pat = 10'b1101001010;  // 0xA5 frame, line order from bit 0

    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    chk_b("reset_txd",  0, txd[0],  1'b1);
    chk_b("reset_busy", 0, busy[0], 1'b0);
    chk_b("reset_done", 1, done[1], 1'b0);

    // Single byte 0xA5
    br = n_ren[0]; bd = n_done[0]; bf = n_fall[0];
    qpush(0, 8'hA5);
    en[0] = 1'b1;
    wait_done(0, bd + 1, 80);
    repeat (3) step();
    f = fall_c[0][bf];
    chk_i("t1_ren_cycles", 0, n_ren[0] - br, 1);
    chk_i("t1_done_latency", 0, done_c[0][bd] - f, 40);
    for (int i = 0; i < 10; i++)
      chk_b($sformatf("t1_bit%0d", i), 0, tr_txd[0][f + 4*i + 1], pat[i]);
    chk_b("t1_busy_after", 0, busy[0], 1'b0);

    // Back-to-back 0x00, 0xFF
    br = n_ren[0]; bd = n_done[0]; bf = n_fall[0];
    qpush(0, 8'h00);
    qpush(0, 8'hFF);
    wait_done(0, bd + 2, 150);
    repeat (2) step();
    d1 = done_c[0][bd];
    d2 = done_c[0][bd + 1];
    r2 = ren_c[0][br + 1];
    chk_i("t2_done_spacing", 0, d2 - d1, 40);
    chk_i("t2_ren_on_last_stop", 0, r2, d1 - 1);
    chk_b("t2_stop_before", 0, tr_txd[0][d1 - 1], 1'b1);
    chk_b("t2_start_after", 0, tr_txd[0][d1], 1'b0);
    cnt = 0;
    for (int c = fall_c[0][bf]; c < d2; c++) if (tr_busy[0][c] !== 1'b1) cnt++;
    chk_i("t2_busy_gaps", 0, cnt, 0);

    // Empty FIFO, then tx_en gating
    br = n_ren[0]; bf = cyc;
    repeat (100) step();
    cnt = 0;
    for (int c = bf; c < cyc; c++) if (tr_txd[0][c] !== 1'b1) cnt++;
    chk_i("t3_empty_ren", 0, n_ren[0] - br, 0);
    chk_i("t3_empty_txd_low", 0, cnt, 0);
    en[0] = 1'b0;
    qpush(0, 8'h3C);
    repeat (10) step();
    chk_i("t3_gated_ren", 0, n_ren[0] - br, 0);
    en[0] = 1'b1;
    bd = n_done[0];
    step();
    chk_i("t3_enable_pop", 0, n_ren[0] - br, 1);
    wait_done(0, bd + 1, 60);

    // tx_en dropped during DATA with two bytes queued
    br = n_ren[0]; bd = n_done[0];
    qpush(0, 8'($urandom));
    qpush(0, 8'($urandom));
    wait_ren(0, br + 1, 5);
    repeat (18) step();
    en[0] = 1'b0;
    wait_done(0, bd + 1, 60);
    repeat (10) step();
    chk_i("t4_single_pop", 0, n_ren[0] - br, 1);
    chk_i("t4_left_queued", 0, qsize(0), 1);
    chk_b("t4_idle", 0, busy[0], 1'b0);
    q0.delete();

    // Reset during data bit 3
    en[0] = 1'b1;
    br = n_ren[0];
    qpush(0, 8'h00);
    wait_ren(0, br + 1, 5);
    repeat (17) step();
    rst = 1'b1;
    step();
    chk_b("t5_rst_txd",  0, txd[0],  1'b1);
    chk_b("t5_rst_busy", 0, busy[0], 1'b0);
    chk_b("t5_rst_done", 0, done[0], 1'b0);
    qpush(0, 8'h5A);
    step();
    rst = 1'b0;
    bd = n_done[0]; bf = n_fall[0];
    wait_done(0, bd + 1, 60);
    chk_i("t5_fresh_frame", 0, done_c[0][bd] - fall_c[0][bf], 40);

    // 7 data bits, 2 stop bits, 3 clocks per bit
    en[1] = 1'b1;
    bd = n_done[1]; bf = n_fall[1];
    qpush(1, 8'h7F);
    wait_done(1, bd + 1, 60);
    f = fall_c[1][bf];
    chk_i("t6_frame_len", 1, done_c[1][bd] - f, 30);
    cnt = 0;
    for (int c = f + 24; c < f + 30; c++) if (tr_txd[1][c] === 1'b1) cnt++;
    chk_i("t6_trailing_high", 1, cnt, 6);
    bd = n_done[1]; bf = n_fall[1];
    qpush(1, 8'h80);
    wait_done(1, bd + 1, 60);
    f2 = fall_c[1][bf];
    for (int i = 1; i <= 7; i++)
      chk_b($sformatf("t6_bit7_ignored_d%0d", i - 1), 1, tr_txd[1][f2 + 3*i + 1], 1'b0);
    chk_b("t6_stop_after_7", 1, tr_txd[1][f2 + 3*8 + 1], 1'b1);

    // Randomized traffic on both channels
    for (int it = 0; it < 1200; it++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(0, 9) == 0 && qsize(ch) < 8) qpush(ch, 8'($urandom));
        if ($urandom_range(0, 59) == 0) en[ch] = ~en[ch];
      end
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    en  = 2'b11;
    k = 0;
    while ((qsize(0) + qsize(1) + int'(m_act[0]) + int'(m_act[1])) != 0 && k < 2000) begin
      step();
      k++;
    end
    chk_i("drain", 0, qsize(0) + qsize(1) + int'(m_act[0]) + int'(m_act[1]), 0);
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
